// File: rtl/alu_pkg.sv
// alu_pkg: shared FSM state type and width constants for the ALU divider
package alu_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);
endpackage

// File: rtl/div_sub_step.sv
// div_sub_step: combinational generate/propagate subtract a-b with borrow-out
module div_sub_step #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  logic [N-1:0] g, p;
  assign g = a & ~b;
  assign p = ~(a ^ b);
  // ripple the carry of a + ~b + 1; a missing final carry means a borrow
  always_comb begin
    logic c;
    c = 1'b1;
    diff = '0;
    for (int i = 0; i < N; i++) begin
      diff[i] = p[i] ^ c;
      c = g[i] | (p[i] & c);
    end
    borrow = ~c;
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle restoring divider; SIGNED_DIV_EN adds signed_op for truncating signed division
module seq_restoring_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH-1:0] q_r, d_r, r_r, q_nx, r_lo, a_mag, b_mag;
  logic [WIDTH:0] t, diff, r_nx;
  logic [CW-1:0] cnt;
  logic borrow, neg_q, neg_r, sg, unused_msb;
`ifdef SIGNED_DIV_EN
  assign sg = signed_op;
`else
  assign sg = 1'b0;
`endif
  assign a_mag = (sg && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_mag = (sg && divisor[WIDTH-1]) ? -divisor : divisor;
  assign t = {r_r, q_r[WIDTH-1]};
  div_sub_step #(.N(WIDTH + 1)) u_sub (
    .a(t),
    .b({1'b0, d_r}),
    .diff(diff),
    .borrow(borrow)
  );
  assign r_nx = borrow ? t : diff;
  assign r_lo = r_nx[WIDTH-1:0];
  assign unused_msb = r_nx[WIDTH];
  assign q_nx = {q_r[WIDTH-2:0], ~borrow};
  assign in_ready = (state == IDLE);
  assign busy = (state != IDLE);
  // control FSM: accept operands, iterate one trial subtraction per clock, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q_r <= '0;
      d_r <= '0;
      r_r <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          q_r <= a_mag;
          d_r <= b_mag;
          r_r <= '0;
          cnt <= '0;
          neg_q <= sg && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r <= sg && dividend[WIDTH-1];
          if (divisor == '0) begin
            state <= DONE;
            quotient <= '1;
            remainder <= dividend;
            div_by_zero <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          q_r <= q_nx;
          r_r <= r_lo;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            quotient <= neg_q ? -q_nx : q_nx;
            remainder <= neg_r ? -r_lo : r_lo;
          end
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          out_valid <= 1'b0;
          div_by_zero <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and random checks of the divider against an arithmetic model
module tb_seq_restoring_divider;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic in_ready, out_valid, div_by_zero, busy;
  logic [W-1:0] quotient, remainder;
`ifdef SIGNED_DIV_EN
  logic signed_op = 1'b0;
`endif
  int checks = 0, failures = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
`ifdef SIGNED_DIV_EN
    .signed_op(signed_op),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1;
    end else if (sg) begin
      q = W'(sa / sb); r = W'(sa % sb); dz = 1'b0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sg,
                        input string tag, input bit hold);
    logic [W-1:0] eq, er;
    logic edz;
    int n;
    model(a, b, sg, eq, er, edz);
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_idle_ready"}, in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor = b;
`ifdef SIGNED_DIV_EN
    signed_op = sg;
`endif
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < W + 4) begin @(negedge clk); n++; end
    chk({tag, "_latency"}, n, (b == 0) ? 0 : W);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, edz);
    chk({tag, "_busy"}, busy, 1);
    if (!sg && b != 0) begin
      chk({tag, "_inv"}, (quotient * b + remainder) & 8'hFF, a);
      chk({tag, "_rlt"}, remainder < b, 1);
    end
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1;
        dividend = ~a;
        divisor = b ^ 8'h5A;
        @(negedge clk);
        chk({tag, "_hold_valid"}, out_valid, 1);
        chk({tag, "_hold_ready"}, in_ready, 0);
        chk({tag, "_hold_q"}, quotient, eq);
        chk({tag, "_hold_r"}, remainder, er);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 0);
    chk({tag, "_post_dz"}, div_by_zero, 0);
    chk({tag, "_post_ready"}, in_ready, 1);
    chk({tag, "_post_busy"}, busy, 0);
    chk({tag, "_post_q"}, quotient, eq);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd100, 8'd7, 1'b0, "u100_7", 1'b0);
    run_op(8'd5, 8'd0, 1'b0, "u5_0", 1'b0);
    run_op(8'd255, 8'd1, 1'b0, "u255_1", 1'b0);
    run_op(8'd3, 8'd200, 1'b0, "u3_200", 1'b0);
    run_op(8'd255, 8'd255, 1'b0, "u255_255", 1'b0);
    run_op(8'd77, 8'd5, 1'b0, "bp77_5", 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor = 8'd9;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd200, 8'd9, 1'b0, "u200_9", 1'b0);
`ifdef SIGNED_DIV_EN
    run_op(8'h9C, 8'd7, 1'b1, "s_m100_7", 1'b0);
    run_op(8'd100, 8'hF9, 1'b1, "s_100_m7", 1'b0);
    run_op(8'h80, 8'hFF, 1'b1, "s_m128_m1", 1'b0);
    run_op(8'h9C, 8'h00, 1'b1, "s_m100_0", 1'b0);
`endif
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
`ifdef SIGNED_DIV_EN
      run_op(ra, rb, 1'($urandom_range(0, 1)), "rand", 1'b0);
`else
      run_op(ra, rb, 1'b0, "rand", 1'b0);
`endif
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
